seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_serializer.sv | 138 +++++++++++++
 tb/tb_seq_serializer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_serializer.sv
// seq_serializer: parallel-word to serial-bit converter with valid/ready load
// handshake, start-of-frame pulse and optional even-parity trailer bit.
// Optional feature macro: SER_PARITY_EN (appends one parity cycle per frame).
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load_valid,
    input  logic [WIDTH-1:0] Load_data,
    output logic             Load_ready,
    output logic             Ser_out,
    output logic             Ser_valid,
    output logic             Sof,
    output logic [1:0]       state
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
`ifdef SER_PARITY_EN
        S_PAR   = 2'b10,
`endif
        S_SHIFT = 2'b01
    } st_t;

    st_t              st, st_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] sreg, sreg_n;
    logic             so_n, sv_n, sof_n;
    logic             accept;
`ifdef SER_PARITY_EN
    logic             par, par_n;
`endif

    // Bit that leaves first from a word, honouring the shift order.
    function automatic logic first_bit(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? d[WIDTH-1] : d[0];
    endfunction

    // Word with its outgoing bit removed, so the next bit sits in the exit slot.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] d);
        return MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
    endfunction

    // Ready comes from registered state only: idle, or presenting the frame's final bit.
    always_comb begin
        Load_ready = 1'b0;
        case (st)
            S_IDLE:  Load_ready = 1'b1;
`ifdef SER_PARITY_EN
            S_SHIFT: Load_ready = 1'b0;
            S_PAR:   Load_ready = 1'b1;
`else
            S_SHIFT: Load_ready = (cnt == LAST);
`endif
            default: Load_ready = 1'b0;
        endcase
    end

    assign accept = Load_valid & Load_ready;
    assign state  = st;

    // Next-state and next-output logic; a fresh accept always wins, since ready
    // is only high where the current frame is finishing or the block is idle.
    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        sreg_n = sreg;
        so_n   = 1'b0;
        sv_n   = 1'b0;
        sof_n  = 1'b0;
`ifdef SER_PARITY_EN
        par_n  = par;
`endif
        if (accept) begin
            st_n   = S_SHIFT;
            cnt_n  = '0;
            so_n   = first_bit(Load_data);
            sreg_n = shift_word(Load_data);
            sv_n   = 1'b1;
            sof_n  = 1'b1;
`ifdef SER_PARITY_EN
            par_n  = ^Load_data;
`endif
        end else begin
            case (st)
                S_SHIFT: begin
                    if (cnt != LAST) begin
                        cnt_n  = cnt + 1'b1;
                        so_n   = first_bit(sreg);
                        sreg_n = shift_word(sreg);
                        sv_n   = 1'b1;
                    end else begin
                        cnt_n = '0;
`ifdef SER_PARITY_EN
                        st_n  = S_PAR;
                        so_n  = par;
                        sv_n  = 1'b1;
`else
                        st_n  = S_IDLE;
`endif
                    end
                end
                default: st_n = S_IDLE;
            endcase
        end
    end

    // State, counter, shift register and registered serial outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            st        <= S_IDLE;
            cnt       <= '0;
            sreg      <= '0;
            Ser_out   <= 1'b0;
            Ser_valid <= 1'b0;
            Sof       <= 1'b0;
`ifdef SER_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            st        <= st_n;
            cnt       <= cnt_n;
            sreg      <= sreg_n;
            Ser_out   <= so_n;
            Ser_valid <= sv_n;
            Sof       <= sof_n;
`ifdef SER_PARITY_EN
            par       <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: one MSB-first and one LSB-first instance fed the
// same load stream; a frame-queue model predicts every output each cycle.
module tb_seq_serializer;
    localparam int W = 8;
`ifdef SER_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic         Clk = 1'b0, Rst = 1'b0, lv = 1'b0;
    logic [W-1:0] ld  = '0;
    logic         rdy_m, so_m, sv_m, sof_m;
    logic         rdy_l, so_l, sv_l, sof_l;
    logic [1:0]   st_m, st_l;
    int           n_chk = 0, n_fail = 0, nsof = 0;

    typedef struct {logic bm; logic bl; logic sof; logic [1:0] st;} exp_t;
    exp_t q[$];
    exp_t cur;
    logic obs_m[$], obs_l[$];

    typedef struct {logic [W-1:0] data; logic [W-1:0] ms; logic [W-1:0] ls; logic par;} vec_t;
    vec_t tab[6];

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .Clk(Clk), .Rst(Rst), .Load_valid(lv), .Load_data(ld), .Load_ready(rdy_m),
        .Ser_out(so_m), .Ser_valid(sv_m), .Sof(sof_m), .state(st_m));
    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .Clk(Clk), .Rst(Rst), .Load_valid(lv), .Load_data(ld), .Load_ready(rdy_l),
        .Ser_out(so_l), .Ser_valid(sv_l), .Sof(sof_l), .state(st_l));

    always #5 Clk = ~Clk;

    function automatic exp_t idle_e();
        exp_t e;
        e.bm = 1'b0; e.bl = 1'b0; e.sof = 1'b0; e.st = 2'b00;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A whole frame becomes a list of future output cycles.
    task automatic push_frame(input logic [W-1:0] d);
        exp_t e;
        for (int i = 0; i < W; i++) begin
            e.bm = d[W-1-i]; e.bl = d[i]; e.sof = (i == 0); e.st = 2'b01;
            q.push_back(e);
        end
        if (PB != 0) begin
            e.bm = ^d; e.bl = ^d; e.sof = 1'b0; e.st = 2'b10;
            q.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("m_out", so_m, cur.bm);
        chk("l_out", so_l, cur.bl);
        chk("m_valid", sv_m, cur.st != 2'b00);
        chk("l_valid", sv_l, cur.st != 2'b00);
        chk("m_sof", sof_m, cur.sof);
        chk("l_sof", sof_l, cur.sof);
        chk("m_state", st_m, cur.st);
        chk("l_state", st_l, cur.st);
        chk("m_ready", rdy_m, q.size() == 0);
        chk("l_ready", rdy_l, q.size() == 0);
    endtask

    // Ready is high exactly when no future cycles of the current frame remain.
    task automatic step();
        @(posedge Clk);
        if (!Rst) q.delete();
        else if (lv && q.size() == 0) push_frame(ld);
        cur = (q.size() != 0) ? q.pop_front() : idle_e();
        #1;
        check_all();
        if (sv_m) begin obs_m.push_back(so_m); obs_l.push_back(so_l); end
        if (sof_m) nsof++;
    endtask

    task automatic do_reset();
        Rst = 1'b0;
        #1;
        q.delete();
        cur = idle_e();
        check_all();
        #2 Rst = 1'b1;
    endtask

    function automatic logic [W-1:0] pack(input int first, input logic which_l);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++)
            v = {v[W-2:0], which_l ? obs_l[first+i] : obs_m[first+i]};
        return v;
    endfunction

    initial begin
        tab[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        tab[1] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
        tab[2] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
        tab[3] = '{8'h07, 8'h07, 8'hE0, 1'b1};
        tab[4] = '{8'h80, 8'h80, 8'h01, 1'b1};
        tab[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};

        cur = idle_e();
        #1 check_all();
        @(negedge Clk) Rst = 1'b1;

        // Isolated frames from the table; data wiggles while not loading.
        for (int t = 0; t < 6; t++) begin
            obs_m.delete(); obs_l.delete(); nsof = 0;
            lv = 1'b1; ld = tab[t].data;
            step();
            lv = 1'b0;
            for (int k = 0; k < W + PB; k++) begin ld = W'($urandom); step(); end
            chk("tab_len", obs_m.size(), W + PB);
            if (obs_m.size() == W + PB) begin
                chk("tab_msb", pack(0, 1'b0), tab[t].ms);
                chk("tab_lsb", pack(0, 1'b1), tab[t].ls);
                if (PB != 0) chk("tab_par", obs_m[W], tab[t].par);
            end
            chk("tab_sof", nsof, 1);
        end

        // Back-to-back A5 then 3C with valid held.
        obs_m.delete(); obs_l.delete(); nsof = 0;
        lv = 1'b1; ld = 8'hA5;
        step();
        ld = 8'h3C;
        repeat (W + PB) step();
        lv = 1'b0;
        repeat (W + PB) step();
        chk("b2b_len", obs_m.size(), 2 * (W + PB));
        if (obs_m.size() == 2 * (W + PB)) begin
            chk("b2b_w0", pack(0, 1'b0), 8'hA5);
            chk("b2b_w1", pack(W + PB, 1'b0), 8'h3C);
        end
        chk("b2b_sof", nsof, 2);

        // Reset during the third bit, then a clean frame right after release.
        lv = 1'b1; ld = 8'hA5;
        step();
        lv = 1'b0;
        step(); step();
        do_reset();
        obs_m.delete(); obs_l.delete(); nsof = 0;
        lv = 1'b1; ld = 8'h3C;
        step();
        lv = 1'b0;
        repeat (W + PB) step();
        chk("rst_len", obs_m.size(), W + PB);
        if (obs_m.size() == W + PB) chk("rst_frame", pack(0, 1'b0), 8'h3C);

        // Valid pulse during bit 4 must be ignored.
        obs_m.delete(); obs_l.delete(); nsof = 0;
        lv = 1'b1; ld = 8'hA5;
        step();
        lv = 1'b0;
        repeat (3) step();
        lv = 1'b1; ld = 8'hFF;
        step();
        lv = 1'b0;
        repeat (W + PB) step();
        chk("pulse_len", obs_m.size(), W + PB);
        if (obs_m.size() == W + PB) chk("pulse_frame", pack(0, 1'b0), 8'hA5);
        chk("pulse_sof", nsof, 1);

        // Random traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            lv = ($urandom_range(0, 3) != 0);
            ld = W'($urandom);
            if ($urandom_range(0, 79) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
